// File: rtl/sr_pkg.sv
// Shared constants for the set/reset command generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sr_pkg;

  // Consecutive synchronised samples a new level must hold before it is accepted.
  localparam int DB_CNT = 4;

  // Width of each debounce counter; must hold DB_CNT-1.
  localparam int CNT_W = 3;

endpackage : sr_pkg

// File: rtl/sr_cmd_gen_if.sv
// Button inputs and latch command outputs of the command generator.
// Latency: n/a (wiring only).
// Backpressure: none; buttons are sampled freely, pulses are fire-and-forget.
interface sr_cmd_gen_if;

  logic set_btn;
  logic rst_btn;
  logic s;
  logic r;
  logic conflict;
  logic set_lvl;
  logic rst_lvl;

  // Stimulus side: drives the raw buttons, observes commands.
  modport master (
    output set_btn,
    output rst_btn,
    input  s,
    input  r,
    input  conflict,
    input  set_lvl,
    input  rst_lvl
  );

  // Generator side: consumes the raw buttons, drives commands.
  modport slave (
    input  set_btn,
    input  rst_btn,
    output s,
    output r,
    output conflict,
    output set_lvl,
    output rst_lvl
  );

endinterface : sr_cmd_gen_if

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, rising-edge detect.
// Latency: lvl follows a stable raw change DB_CNT+2 edges after it is first sampled.
// Backpressure: none; rise is a one-cycle strobe for every accepted 0->1 change.
module sr_debounce #(
  parameter int DB_CNT = sr_pkg::DB_CNT,
  parameter int CNT_W  = sr_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic lvl,
  output logic rise
);

  // Terminal count: the DB_CNT-th consecutive differing sample flips the level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_lvl;
  logic             r_lvl_q;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the raw button, qualify level changes and keep the previous level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_lvl_q <= r_lvl;
      if (r_sync2 == r_lvl) begin
        // Any agreeing sample restarts qualification.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_lvl <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign lvl  = r_lvl;
  assign rise = r_lvl & ~r_lvl_q;

endmodule : sr_debounce

// File: rtl/sr_cmd_gen.sv
// Turns two bouncing buttons into mutually exclusive one-cycle set/reset pulses.
// Latency: pulse appears DB_CNT+3 edges after a clean raw rise is first sampled.
// Backpressure: none; simultaneous rises raise conflict and forward neither pulse.
module sr_cmd_gen #(
  parameter int DB_CNT = sr_pkg::DB_CNT,
  parameter int CNT_W  = sr_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  sr_cmd_gen_if.slave  bus
);

  logic w_set_lvl;
  logic w_set_rise;
  logic w_rst_lvl;
  logic w_rst_rise;

  logic r_s;
  logic r_r;
  logic r_conflict;

  sr_debounce #(
    .DB_CNT (DB_CNT),
    .CNT_W  (CNT_W)
  ) u_set_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (bus.set_btn),
    .lvl    (w_set_lvl),
    .rise   (w_set_rise)
  );

  sr_debounce #(
    .DB_CNT (DB_CNT),
    .CNT_W  (CNT_W)
  ) u_rst_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (bus.rst_btn),
    .lvl    (w_rst_lvl),
    .rise   (w_rst_rise)
  );

  // Register the commands; a same-cycle pair of rises is reported, never forwarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_s        <= w_set_rise & ~w_rst_rise;
      r_r        <= w_rst_rise & ~w_set_rise;
      r_conflict <= w_set_rise &  w_rst_rise;
    end
  end

  assign bus.s        = r_s;
  assign bus.r        = r_r;
  assign bus.conflict = r_conflict;
  assign bus.set_lvl  = w_set_lvl;
  assign bus.rst_lvl  = w_rst_lvl;

endmodule : sr_cmd_gen
